// File: rtl/code_fetch.sv
// code_fetch: instruction-fetch front end for the code memory.
// Owns the fetch PC, drives the memory address with rw held at read, captures the
// returned bytes with their addresses into a prefetch FIFO, and delivers them in
// program order over a valid/ready handshake. A redirect flushes the FIFO and
// reloads the fetch PC.
//
// Ports:
//   clock, reset        - clock, asynchronous active-high reset
//   rw, add_bus         - code memory read select (always 1) and address (= fetch_pc)
//   data_bus            - code memory read data (combinational from add_bus)
//   redirect            - flush FIFO and load redirect_pc as the new fetch PC
//   redirect_pc         - target address sampled on redirect
//   byte_valid          - FIFO head valid
//   byte_data, byte_pc  - FIFO head byte and the address it was fetched from
//   byte_ready          - downstream accepts the head this cycle
//   addr_err            - sticky fetch-range error
//
// Configuration macro: CODE_FETCH_WRAP_EN
//   defined   - fetch PC wraps modulo MEM_BYTES, redirect targets are masked,
//               addr_err is tied low and HALT is never entered
//   undefined - running off the end of memory or redirecting out of range enters
//               HALT and raises addr_err until reset or an in-range redirect
module code_fetch #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rw,
  output logic [15:0] add_bus,
  input  logic [7:0]  data_bus,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [15:0] byte_pc,
  input  logic        byte_ready,
  output logic        addr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] PC_MASK = 16'(MEM_BYTES - 1);

  typedef enum logic {StRun, StHalt} state_t;

  state_t          state;
  logic [15:0]     fetch_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [23:0]     fifo_mem [DEPTH];

  logic            pop;
  logic            push;
  logic [15:0]     pc_inc;
  logic            inc_oob;
  logic [15:0]     redir_pc_n;
  logic            redir_oob;

  assign rw         = 1'b1;
  assign add_bus    = fetch_pc;
  assign byte_valid = (count != '0);
  assign byte_pc    = fifo_mem[rd_ptr][23:8];
  assign byte_data  = fifo_mem[rd_ptr][7:0];

  always_comb begin
    // A redirect cycle never consumes the head, even if the handshake is up.
    pop  = byte_valid & byte_ready & ~redirect;
    // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
    push = (state == StRun) & ~redirect & ((count < CW'(DEPTH)) | pop);
`ifdef CODE_FETCH_WRAP_EN
    pc_inc     = (fetch_pc + 16'd1) & PC_MASK;
    inc_oob    = 1'b0;
    redir_pc_n = redirect_pc & PC_MASK;
    redir_oob  = 1'b0;
`else
    pc_inc     = fetch_pc + 16'd1;
    inc_oob    = (fetch_pc == PC_MASK);
    redir_pc_n = redirect_pc;
    redir_oob  = ({1'b0, redirect_pc} >= 17'(MEM_BYTES));
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= StRun;
      fetch_pc <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (redirect) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redir_pc_n;
      state    <= redir_oob ? StHalt : StRun;
      addr_err <= redir_oob;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {fetch_pc, data_bus};
        wr_ptr           <= wr_ptr + PW'(1);
        fetch_pc         <= pc_inc;
        if (inc_oob) begin
          state    <= StHalt;
          addr_err <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/code_fetch.md
# code_fetch

Instruction-fetch front end that sits directly upstream of the 8 KB code memory. It owns the fetch program counter, drives the memory's address bus with `rw` held at read, and captures the returned bytes into a small prefetch FIFO. It delivers bytes in program order to the downstream decoder over a valid/ready handshake, and supports a flush-and-redirect for jumps.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, 2..16.
- `MEM_BYTES`, 8192: code memory size in bytes; power of two.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `rw`  out  1  code memory read/write select; constant 1 (read).
- `add_bus`  out  16  code memory address; equals `fetch_pc` register.
- `data_bus`  in  8  code memory read data; combinational function of `add_bus`.
- `redirect`  in  1  flush FIFO and load new fetch address.
- `redirect_pc`  in  16  target address, sampled when `redirect`=1.
- `byte_valid`  out  1  FIFO head is valid.
- `byte_data`  out  8  FIFO head byte.
- `byte_pc`  out  16  address the head byte was fetched from.
- `byte_ready`  in  1  decoder accepts the head this cycle.
- `addr_err`  out  1  sticky fetch-range error; see Configuration.

## Operation
- State machine `state` has two states, RUN and HALT. HALT is reachable only without the macro.
- FIFO entries hold {pc[15:0], data[7:0]}. Storage uses read/write pointers plus a `count` register of width $clog2(DEPTH)+1.
- Pop: `byte_valid & byte_ready`, outside a redirect cycle.
- Push: in state RUN, no redirect, and (`count`<DEPTH or pop). This allows simultaneous push and pop when full, which keeps `count` at DEPTH.
- On push:
  - entry = {`fetch_pc`, `data_bus`} sampled at posedge;
  - `fetch_pc` <= `fetch_pc`+1, subject to the range rules in Configuration.
- With no push, `fetch_pc` holds and `add_bus` stays stable.
- Redirect has the highest priority:
  - FIFO is emptied (`count`<=0, pointers reset);
  - `fetch_pc` <= `redirect_pc` (range rules apply);
  - any same-cycle push is dropped, and any same-cycle handshake is not a pop;
  - `addr_err` is cleared, then re-evaluated against the new PC;
  - state returns to RUN unless the new PC is out of range.
- `byte_data` and `byte_pc` are undefined while `byte_valid`=0.
- No combinational path from `byte_ready` to `add_bus` or `rw`.

## Timing
Reset values:
- `fetch_pc`=0x0000, `add_bus`=0x0000, `rw`=1.
- `byte_valid`=0, `byte_data`=0x00, `byte_pc`=0x0000.
- `addr_err`=0, `count`=0, state=RUN.

Reset asserted mid-operation discards all FIFO contents immediately, with no clock required.

Latency:
- First byte is captured at the first posedge after reset deasserts; `byte_valid`=1 in the following cycle.
- Redirect at posedge N: `add_bus`=`redirect_pc` during cycle N..N+1; byte captured at posedge N+1; `byte_valid`=1 after N+1.
- Steady state with `byte_ready`=1: one byte per cycle, no bubbles.
- Backpressure: after `byte_ready` drops, at most DEPTH bytes are buffered, then pushes stop. A pop re-enables the push in the same cycle.

## Configuration
Macro `CODE_FETCH_WRAP_EN`.

Defined:
- `fetch_pc` increments modulo MEM_BYTES (0x1FFF -> 0x0000).
- `redirect_pc` is masked to its low $clog2(MEM_BYTES) bits.
- `addr_err` is tied to 0 and HALT is never entered.

Not defined:
- A push at `fetch_pc`=MEM_BYTES-1 increments to MEM_BYTES and enters HALT.
- A redirect with `redirect_pc`>=MEM_BYTES loads the PC unmasked and enters HALT.
- In HALT: no pushes, `addr_err`=1; buffered bytes still drain normally.
- HALT exits only via reset, or via a redirect to an in-range address.

## Test plan
- Memory preloaded with 0x00..0x0F at 0x0000, `byte_ready`=1 after reset -> `byte_valid` rises cycle 2; bytes 0x00,0x01,0x02… one per cycle with `byte_pc` 0,1,2….
- `byte_ready`=0 for 10 cycles, DEPTH=4 -> `count` saturates at 4 and `add_bus` holds 0x0004. Then `byte_ready`=1 -> bytes 0x00..0x03 followed by 0x04 with no gap or duplicate.
- FIFO full and `byte_ready`=1 -> push and pop in the same cycle, `count` stays 4, ordering preserved.
- `redirect`=1 with `redirect_pc`=0x0100 while FIFO holds 3 bytes and `byte_ready`=1 -> those 3 bytes are never popped; the next valid byte has `byte_pc`=0x0100, two cycles later.
- With the macro: redirect to 0x1FFE -> `byte_pc` sequence 0x1FFE, 0x1FFF, 0x0000. Without the macro: same stimulus -> 0x1FFE, 0x1FFF, then `addr_err`=1 and no further bytes. Redirect to 0x0000 then clears `addr_err` and fetch resumes.
- Assert `reset` asynchronously mid-stream with FIFO non-empty -> `byte_valid`=0 and `add_bus`=0 before the next posedge.
